// File: rtl/sevenseg_scan_decoder.sv
// Readback monitor for a 4-digit multiplexed active-low seven-segment display.
// Define SEVENSEG_SYNC_EN to add 2-flop synchronizers on segment_/digit_enable_.
module sevenseg_scan_decoder #(
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  segment_,
    input  logic [3:0]  digit_enable_,
    input  logic        err_clr,
    output logic [15:0] digits,
    output logic        valid,
    output logic        frame_strobe,
    output logic        changed,
    output logic        err,
    output logic        stalled
);
    // state  | meaning
    // IDLE   | no legal digit select on the bus
    // SETTLE | legal select seen, waiting for enable+segments to stay stable
    // HOLD   | digit captured, waiting for the bus to move on
    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] SETTLE_LOAD  = SW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(TIMEOUT_CYCLES - 1);

    logic [6:0] seg_in;
    logic [3:0] en_in;

`ifdef SEVENSEG_SYNC_EN
    logic [6:0] seg_m, seg_s;
    logic [3:0] en_m, en_s;
    always_ff @(posedge clk) begin
        if (reset) begin
            seg_m <= '1;
            seg_s <= '1;
            en_m  <= '1;
            en_s  <= '1;
        end else begin
            seg_m <= segment_;
            seg_s <= seg_m;
            en_m  <= digit_enable_;
            en_s  <= en_m;
        end
    end
    assign seg_in = seg_s;
    assign en_in  = en_s;
`else
    assign seg_in = segment_;
    assign en_in  = digit_enable_;
`endif

    state_t          state, state_nx;
    logic [SW-1:0]   settle_cnt, settle_nx;
    logic [TW-1:0]   stall_cnt;
    logic [6:0]      seg_q;
    logic [3:0]      en_q;
    logic [3:0]      seen;
    logic            capture;
    logic            sel_legal, en_illegal;
    logic [1:0]      sel_idx;
    logic [3:0]      code;
    logic            code_bad;
    logic            en_chg, seg_chg;
    logic [3:0]      seen_upd;
    logic [3:0]      old_code;

    assign en_chg   = (en_in != en_q);
    assign seg_chg  = (seg_in != seg_q);
    assign seen_upd = seen | ~en_in;
    assign old_code = digits[{sel_idx, 2'b00} +: 4];

    always_comb begin
        sel_legal  = 1'b0;
        en_illegal = 1'b0;
        sel_idx    = 2'd0;
        case (en_in)
            4'b1110: begin sel_legal = 1'b1; sel_idx = 2'd0; end
            4'b1101: begin sel_legal = 1'b1; sel_idx = 2'd1; end
            4'b1011: begin sel_legal = 1'b1; sel_idx = 2'd2; end
            4'b0111: begin sel_legal = 1'b1; sel_idx = 2'd3; end
            4'b1111: ;
            default: en_illegal = 1'b1;
        endcase
    end

    // Decoded on lit segments, g..a from MSB to LSB.
    always_comb begin
        code     = 4'hF;
        code_bad = 1'b0;
        case (~seg_in)
            7'b0111111: code = 4'h0;
            7'b0000110: code = 4'h1;
            7'b1011011: code = 4'h2;
            7'b1001111: code = 4'h3;
            7'b1100110: code = 4'h4;
            7'b1101101: code = 4'h5;
            7'b1111101: code = 4'h6;
            7'b0000111: code = 4'h7;
            7'b1111111: code = 4'h8;
            7'b1101111: code = 4'h9;
            7'b1000000: code = 4'hA;
            7'b0000000: code = 4'hB;
            default:    code_bad = 1'b1;
        endcase
    end

    always_comb begin
        state_nx  = state;
        settle_nx = settle_cnt;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (sel_legal) begin
                    state_nx  = SETTLE;
                    settle_nx = SETTLE_LOAD;
                end
            end
            SETTLE, HOLD: begin
                if (en_chg) begin
                    state_nx  = sel_legal ? SETTLE : IDLE;
                    settle_nx = SETTLE_LOAD;
                end else if (seg_chg) begin
                    state_nx  = SETTLE;
                    settle_nx = SETTLE_LOAD;
                end else if (state == SETTLE) begin
                    if (settle_cnt == '0) begin
                        capture  = 1'b1;
                        state_nx = HOLD;
                    end else begin
                        settle_nx = settle_cnt - SW'(1);
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            settle_cnt   <= SETTLE_LOAD;
            stall_cnt    <= TIMEOUT_LOAD;
            seg_q        <= '1;
            en_q         <= '1;
            seen         <= '0;
            digits       <= 16'hFFFF;
            valid        <= 1'b0;
            frame_strobe <= 1'b0;
            changed      <= 1'b0;
            err          <= 1'b0;
            stalled      <= 1'b0;
        end else begin
            state        <= state_nx;
            settle_cnt   <= settle_nx;
            seg_q        <= seg_in;
            en_q         <= en_in;
            frame_strobe <= 1'b0;
            changed      <= 1'b0;
            if (capture) begin
                digits[{sel_idx, 2'b00} +: 4] <= code;
                changed <= (code != old_code);
                if (seen_upd == 4'hF) begin
                    frame_strobe <= 1'b1;
                    valid        <= 1'b1;
                    seen         <= '0;
                end else begin
                    seen <= seen_upd;
                end
            end
            // A new error in the same cycle beats the clear request.
            err <= ((capture && code_bad) || en_illegal) ? 1'b1 : (err && !err_clr);
            if (en_chg) begin
                stall_cnt <= TIMEOUT_LOAD;
                stalled   <= 1'b0;
            end else if (stall_cnt == '0) begin
                stalled <= 1'b1;
            end else begin
                stall_cnt <= stall_cnt - TW'(1);
            end
        end
    end
endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// Directed bench for sevenseg_scan_decoder (SETTLE_CYCLES=16, TIMEOUT_CYCLES=64, no sync).
module tb_sevenseg_scan_decoder;
    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  segment_;
    logic [3:0]  digit_enable_;
    logic        err_clr;
    logic [15:0] digits;
    logic        valid, frame_strobe, changed, err, stalled;

    int checks = 0;
    int errors = 0;
    int chg_cnt = 0;
    int fs_cnt = 0;

    localparam logic [6:0] P1 = 7'b0000110;
    localparam logic [6:0] P2 = 7'b1011011;
    localparam logic [6:0] P3 = 7'b1001111;
    localparam logic [6:0] P4 = 7'b1100110;
    localparam logic [6:0] P5 = 7'b1101101;
    localparam logic [6:0] P7 = 7'b0000111;
    localparam logic [6:0] P8 = 7'b1111111;
    localparam logic [6:0] PBAD = 7'b0101010;

    sevenseg_scan_decoder #(.SETTLE_CYCLES(16), .TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .reset(reset), .segment_(segment_), .digit_enable_(digit_enable_),
        .err_clr(err_clr), .digits(digits), .valid(valid), .frame_strobe(frame_strobe),
        .changed(changed), .err(err), .stalled(stalled)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (changed) chg_cnt++;
        if (frame_strobe) fs_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] en, input logic [6:0] lit);
        digit_enable_ = en;
        segment_      = ~lit;
    endtask

    initial begin
        reset = 1'b1;
        err_clr = 1'b0;
        segment_ = '1;
        digit_enable_ = '1;

        // 1: reset state
        tick(3);
        chk("rst_digits", 32'(digits), 32'hFFFF);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_stalled", 32'(stalled), 0);
        chk("rst_changed", 32'(changed), 0);
        chk("rst_fs", 32'(frame_strobe), 0);
        reset = 1'b0;

        // 2: scan "1234", exact capture latency on first and last digit
        drive(4'b1110, P1);
        tick(16);
        chk("lat_d0_early", 32'(digits), 32'hFFFF);
        chk("lat_d0_chg_early", 32'(changed), 0);
        tick(1);
        chk("lat_d0", 32'(digits), 32'hFFF1);
        chk("lat_d0_chg", 32'(changed), 1);
        chk("lat_d0_fs", 32'(frame_strobe), 0);
        tick(3);
        drive(4'b1101, P2);
        tick(20);
        drive(4'b1011, P3);
        tick(20);
        chk("scan_partial", 32'(digits), 32'hF321);
        chk("scan_valid_partial", 32'(valid), 0);
        drive(4'b0111, P4);
        tick(16);
        chk("fs_early", 32'(frame_strobe), 0);
        tick(1);
        chk("fs_pulse", 32'(frame_strobe), 1);
        chk("scan_valid", 32'(valid), 1);
        tick(3);
        chk("scan_digits", 32'(digits), 32'h4321);
        chk("scan_chg_cnt", 32'(chg_cnt), 4);
        chk("scan_fs_cnt", 32'(fs_cnt), 1);
        chk("scan_err", 32'(err), 0);

        // 3: glitch shorter than settle time
        drive(4'b1110, P7);
        tick(10);
        drive(4'b1111, P8);
        tick(20);
        chk("glitch_digits", 32'(digits), 32'h4321);
        chk("glitch_chg_cnt", 32'(chg_cnt), 4);

        // 4: invalid pattern, err_clr, and set-beats-clear
        drive(4'b1011, PBAD);
        tick(20);
        chk("bad_digits", 32'(digits), 32'h4F21);
        chk("bad_err", 32'(err), 1);
        chk("bad_chg_cnt", 32'(chg_cnt), 5);
        drive(4'b1111, P8);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("errclr", 32'(err), 0);
        tick(2);
        chk("errclr_hold", 32'(err), 0);
        drive(4'b1011, PBAD);
        tick(16);
        chk("coinc_pre", 32'(err), 0);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("coinc_err", 32'(err), 1);
        chk("coinc_nochg", 32'(changed), 0);
        tick(3);
        chk("coinc_digits", 32'(digits), 32'h4F21);

        // 5: illegal enable, then stall timeout
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("pre_illegal_err", 32'(err), 0);
        drive(4'b1100, P8);
        tick(20);
        chk("illegal_err", 32'(err), 1);
        chk("illegal_digits", 32'(digits), 32'h4F21);
        drive(4'b1111, P8);
        tick(1);
        tick(63);
        chk("stall_early", 32'(stalled), 0);
        tick(1);
        chk("stall_set", 32'(stalled), 1);
        drive(4'b1110, P8);
        tick(1);
        chk("stall_clr", 32'(stalled), 0);

        // 6: reset in the middle of a settle discards it
        reset = 1'b1;
        drive(4'b1111, P8);
        tick(2);
        reset = 1'b0;
        drive(4'b1101, P5);
        tick(11);
        reset = 1'b1;
        tick(2);
        chk("midrst_digits", 32'(digits), 32'hFFFF);
        chk("midrst_valid", 32'(valid), 0);
        chk("midrst_err", 32'(err), 0);
        chk("midrst_stalled", 32'(stalled), 0);
        chk("midrst_changed", 32'(changed), 0);
        reset = 1'b0;
        tick(12);
        chk("midrst_nocap", 32'(digits), 32'hFFFF);
        tick(6);
        chk("midrst_recap", 32'(digits), 32'hFF5F);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
